guess_game_ctrl: RTL and testbench



---
 rtl/guess_game_ctrl.sv | 151 +++++++++++++++
 tb/tb_guess_game_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/guess_game_ctrl.sv
// Two-digit number-guessing game controller: keypad presses -> BCD guess,
// compare against a latched secret, count tries, drive display digits and hints.
module guess_game_ctrl #(
    parameter logic [7:0] MAX_TRIES = 8'h07
) (
    input  logic        clk,
    input  logic        RSTn,
    input  logic [15:0] key_deb,
    output logic [15:0] disp_digits,
    output logic [3:0]  disp_blank,
    output logic [1:0]  hint,
    output logic        won,
    output logic        lost
);

    localparam int unsigned KEY_W  = 16;
    localparam int unsigned BCD_W  = 8;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [2:0] {IDLE, INPUT, CHECK, WIN, LOSE} state_t;

    state_t              state, state_d;
    logic [KEY_W-1:0]    key_prev, rise;
    logic [CODE_W-1:0]   press_code;
    logic                press_valid, is_digit, is_enter, is_clear, is_new;
    logic [BCD_W-1:0]    rnd_cnt, secret, secret_d, guess, guess_d, tries, tries_d;
    logic [CNT_W-1:0]    count, count_d;
    logic [1:0]          hint_d;
    logic [15:0]         digits_d;
    logic [3:0]          blank_d;

    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd9) return 8'h00;
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // A press is a single newly-risen key; simultaneous rises are discarded.
    assign rise        = key_deb & ~key_prev;
    assign press_valid = (rise != '0) && ((rise & (rise - 16'd1)) == '0);

    always_comb begin
        press_code = '0;
        for (int i = 0; i < KEY_W; i++) begin
            if (rise[i]) press_code = CODE_W'(i);
        end
    end

    assign is_digit = press_valid && (press_code <= 4'd9);
    assign is_enter = press_valid && (press_code == 4'd10);
    assign is_clear = press_valid && (press_code == 4'd11);
    assign is_new   = press_valid && (press_code == 4'd12);

    always_ff @(posedge clk) begin
        if (!RSTn) state <= IDLE;
        else       state <= state_d;
    end

    // Next state, game datapath and next display values.
    always_comb begin
        state_d  = state;
        guess_d  = guess;
        tries_d  = tries;
        count_d  = count;
        hint_d   = hint;
        secret_d = secret;
        digits_d = '0;
        blank_d  = 4'b1111;

        unique case (state)
            IDLE, WIN, LOSE: ;
            INPUT: begin
                if (is_digit) begin
                    guess_d = (count == '0) ? {4'd0, press_code} : {guess[3:0], press_code};
                    count_d = (count == CNT_W'(2)) ? count : count + CNT_W'(1);
                end else if (is_clear) begin
                    guess_d = '0;
                    count_d = '0;
                end else if (is_enter && count != '0) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                tries_d = (tries == 8'h99) ? tries : bcd_inc(tries);
                if (guess == secret) begin
                    hint_d  = 2'b11;
                    state_d = WIN;
                end else begin
                    hint_d = (guess < secret) ? 2'b01 : 2'b10;
                    if (tries_d == MAX_TRIES) begin
                        state_d = LOSE;
                    end else begin
                        state_d = INPUT;
                        count_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // New game is accepted everywhere except the one-cycle CHECK.
        if (is_new && state != CHECK) begin
            state_d  = INPUT;
            secret_d = rnd_cnt;
            tries_d  = '0;
            guess_d  = '0;
            count_d  = '0;
            hint_d   = 2'b00;
        end

        digits_d = {tries_d, (state_d == LOSE) ? secret_d : guess_d};
        if (state_d != IDLE) begin
            if (state_d == INPUT && count_d == '0 && tries_d == '0) blank_d = 4'b0011;
            else if (state_d == INPUT && count_d == CNT_W'(1))     blank_d = 4'b0010;
            else                                                    blank_d = 4'b0000;
            blank_d[3] = (tries_d < 8'h10);
        end
    end

    always_ff @(posedge clk) begin
        if (!RSTn) begin
            key_prev    <= '0;
            rnd_cnt     <= '0;
            secret      <= '0;
            guess       <= '0;
            tries       <= '0;
            count       <= '0;
            hint        <= 2'b00;
            disp_digits <= '0;
            disp_blank  <= 4'b1111;
            won         <= 1'b0;
            lost        <= 1'b0;
        end else begin
            key_prev    <= key_deb;
            rnd_cnt     <= bcd_inc(rnd_cnt);
            secret      <= secret_d;
            guess       <= guess_d;
            tries       <= tries_d;
            count       <= count_d;
            hint        <= hint_d;
            disp_digits <= digits_d;
            disp_blank  <= blank_d;
            won         <= (state_d == WIN);
            lost        <= (state_d == LOSE);
        end
    end

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Scoreboard bench for guess_game_ctrl: stimulus queues expected display
// words by cycle, a negedge monitor pops and compares them.
module tb_guess_game_ctrl;

    logic        clk;
    logic        RSTn;
    logic [15:0] key_deb;
    logic [15:0] disp_digits;
    logic [3:0]  disp_blank;
    logic [1:0]  hint;
    logic        won;
    logic        lost;

    guess_game_ctrl #(.MAX_TRIES(8'h03)) dut (.*);

    typedef struct {
        int          due;
        string       name;
        logic [23:0] exp;
        bit          tmo;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   secdec = 0;
    int   checks = 0;
    int   errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Decimal reference for the free-running secret counter.
    always @(posedge clk) begin
        if (!RSTn) secdec <= 0;
        else       secdec <= (secdec == 99) ? 0 : secdec + 1;
    end

    function automatic logic [23:0] pk(input logic [15:0] d, input logic [3:0] b,
                                       input logic [1:0] h, input logic w, input logic l);
        return {d, b, h, w, l};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic [23:0] act;
        act = {disp_digits, disp_blank, hint, won, lost};
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.tmo) begin
                errors++;
                $display("FAIL %s: timed out waiting for secret counter", e.name);
            end else if (e.due != cyc) begin
                errors++;
                $display("FAIL %s: check missed, due cycle %0d now %0d", e.name, e.due, cyc);
            end else if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h (digits,blank,hint,won,lost)",
                         e.name, act, e.exp);
            end
        end
    end

    task automatic expect_in(input int d, input string n, input logic [23:0] e);
        sb.push_back('{cyc + d, n, e, 1'b0});
    endtask

    // Called at a negedge; one-cycle press then one low cycle.
    task automatic press(input int k, input int d, input string n, input logic [23:0] e);
        key_deb = 16'(1) << k;
        expect_in(d, n, e);
        @(negedge clk);
        key_deb = '0;
        @(negedge clk);
    endtask

    task automatic new_game_42(input string n);
        for (int i = 0; i < 200 && secdec != 42; i++) @(negedge clk);
        if (secdec != 42) sb.push_back('{cyc + 1, n, 24'h0, 1'b1});
        press(12, 1, n, pk(16'h0000, 4'b1011, 2'b00, 1'b0, 1'b0));
    endtask

    initial begin
        RSTn    = 1'b0;
        key_deb = '0;
        @(negedge clk);
        expect_in(1, "reset", pk(16'h0000, 4'b1111, 2'b00, 1'b0, 1'b0));
        @(negedge clk);
        RSTn = 1'b1;
        repeat (3) @(negedge clk);

        // Two wrong guesses: low then high.
        new_game_42("new_game");
        press(3,  1, "digit3",     pk(16'h0003, 4'b1010, 2'b00, 1'b0, 1'b0));
        press(5,  1, "digit5",     pk(16'h0035, 4'b1000, 2'b00, 1'b0, 1'b0));
        press(10, 2, "enter_low",  pk(16'h0135, 4'b1000, 2'b01, 1'b0, 1'b0));
        press(5,  1, "digit5b",    pk(16'h0105, 4'b1010, 2'b01, 1'b0, 1'b0));
        press(0,  1, "digit0",     pk(16'h0150, 4'b1000, 2'b01, 1'b0, 1'b0));
        press(10, 2, "enter_high", pk(16'h0250, 4'b1000, 2'b10, 1'b0, 1'b0));

        // Ignored inputs: enter with no digits, two simultaneous rises.
        press(10, 2, "enter_cnt0", pk(16'h0250, 4'b1000, 2'b10, 1'b0, 1'b0));
        key_deb = 16'h0280;
        expect_in(1, "double_rise", pk(16'h0250, 4'b1000, 2'b10, 1'b0, 1'b0));
        @(negedge clk);
        key_deb = '0;
        @(negedge clk);

        // Held key enters once.
        key_deb = 16'(1) << 5;
        expect_in(1, "hold5_first", pk(16'h0205, 4'b1010, 2'b10, 1'b0, 1'b0));
        repeat (100) @(negedge clk);
        expect_in(1, "hold5_after", pk(16'h0205, 4'b1010, 2'b10, 1'b0, 1'b0));
        @(negedge clk);
        key_deb = '0;
        @(negedge clk);

        // Third wrong guess loses and shows the secret.
        press(1,  1, "digit1",     pk(16'h0251, 4'b1000, 2'b10, 1'b0, 1'b0));
        press(10, 2, "enter_lose", pk(16'h0342, 4'b1000, 2'b10, 1'b0, 1'b1));
        press(4,  1, "lose_hold",  pk(16'h0342, 4'b1000, 2'b10, 1'b0, 1'b1));

        // Restart from LOSE and win with an oldest digit shifted out.
        new_game_42("new_from_lose");
        press(1,  1, "w_digit1",   pk(16'h0001, 4'b1010, 2'b00, 1'b0, 1'b0));
        press(4,  1, "w_digit4",   pk(16'h0014, 4'b1000, 2'b00, 1'b0, 1'b0));
        press(2,  1, "w_digit2",   pk(16'h0042, 4'b1000, 2'b00, 1'b0, 1'b0));
        press(10, 2, "enter_win",  pk(16'h0142, 4'b1000, 2'b11, 1'b1, 1'b0));
        press(7,  1, "win_hold",   pk(16'h0142, 4'b1000, 2'b11, 1'b1, 1'b0));

        // Clear key, then reset mid-game and start fresh.
        new_game_42("new_from_win");
        press(3,  1, "m_digit3",   pk(16'h0003, 4'b1010, 2'b00, 1'b0, 1'b0));
        press(11, 1, "clear",      pk(16'h0000, 4'b1011, 2'b00, 1'b0, 1'b0));
        press(8,  1, "m_digit8",   pk(16'h0008, 4'b1010, 2'b00, 1'b0, 1'b0));
        RSTn = 1'b0;
        expect_in(1, "mid_reset", pk(16'h0000, 4'b1111, 2'b00, 1'b0, 1'b0));
        @(negedge clk);
        RSTn = 1'b1;
        @(negedge clk);
        new_game_42("new_after_reset");
        press(9,  1, "r_digit9",   pk(16'h0009, 4'b1010, 2'b00, 1'b0, 1'b0));
        press(10, 2, "enter_one",  pk(16'h0109, 4'b1000, 2'b01, 1'b0, 1'b0));

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
